ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter profundidad, default 1024, RAM depth in 32-bit words; AW = ceil(log2(profundidad)) address bits.
REQ-002 SHALL have parameter NPORTS, fixed 2, number of requesters (0 = CPU data port, 1 = loader/debug port).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1  access request, held until matching ack.
REQ-006 we0/we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0/addr1  input  AW  word address; stable while req high.
REQ-008 wdata0/wdata1  input  32  write data; stable while req high.
REQ-009 ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 rdata0/rdata1  output  32  read result, valid in the ack cycle, held until that port's next ack.
REQ-011 ram_address  output  AW  to RAM address.
REQ-012 ram_write_data  output  32  to RAM write data.
REQ-013 ram_MemWrite  output  1  RAM write enable.
REQ-014 ram_MemRead  output  1  RAM read strobe.
REQ-015 ram_read_data  input  32  combinational RAM read data.

Function
REQ-016 SHALL use FSM IDLE -> ACCESS -> DONE -> IDLE; one access per 3 cycles.
REQ-017 IDLE: if any req high, select winner, register its we/addr/wdata and id, go ACCESS; else stay IDLE.
REQ-018 ACCESS: drive ram_address/ram_write_data from registers; ram_MemWrite = we, ram_MemRead = !we; read: capture ram_read_data into winner's rdata at end of cycle; go DONE.
REQ-019 DONE: assert ack of winner only, RAM strobes low; go IDLE.
REQ-020 Outside ACCESS, ram_MemWrite and ram_MemRead SHALL be 0; ram_address/ram_write_data hold last registered values.
REQ-021 Latency: request sampled in IDLE at edge N -> ack high in cycle N+2.
REQ-022 Requester SHALL deassert req at the edge ending its ack cycle unless issuing a new request; req seen in the IDLE that follows is a new request (back-to-back allowed).
REQ-023 req is sampled only in IDLE; changes in ACCESS/DONE are ignored.
REQ-024 On write, rdata of the winner SHALL be unchanged.
REQ-025 Simultaneous req0 and req1 in IDLE: resolved per Configuration; loser waits, never dropped.
REQ-026 Address out of range (>= profundidad) passed through unchanged; no check.

Reset
REQ-027 reset_n low SHALL force IDLE, ack0/ack1 = 0, rdata0/rdata1 = 0, ram_MemWrite = ram_MemRead = 0, ram_address = 0, ram_write_data = 0, priority pointer to port 0.
REQ-028 Reset during ACCESS SHALL abort: no ack issued, write strobe drops immediately; requester re-issues.

Configuration
REQ-029 Macro RAM_ARB_RR_EN defined: round-robin; after grant to port k, port (1-k) has priority on the next tie.
REQ-030 RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; no pointer register.

Structure
REQ-031 Package ram_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, DONE), NPORTS and port-id constants.
REQ-032 Sub-module ram_arb_sel SHALL implement winner selection (requests + pointer -> one-hot grant, id).

Verification
REQ-033 Single read: RAM[5]=0xDEADBEEF, req0 read addr 5 at cycle 0 -> ack0 cycle 2, rdata0=0xDEADBEEF, ack1 never.
REQ-034 Write then read: req1 write addr 10 data 0x12345678, then read addr 10 -> second ack1 rdata1=0x12345678; ram_MemWrite high exactly 1 cycle.
REQ-035 Tie with RAM_ARB_RR_EN: req0 and req1 held continuously for 4 accesses -> acks alternate 0,1,0,1; without macro -> 0,1 only after req0 drops.
REQ-036 Back-to-back: req0 kept high over 3 accesses -> acks at cycles 2,5,8, no idle gap.
REQ-037 Reset mid-ACCESS: write req, reset_n low in ACCESS -> no ack, MemWrite 0 immediately, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NPORTS = 2;
    localparam int unsigned DW     = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arb_sel.sv
// Winner selection: a tie goes to the port named by prio_i; a lone requester always wins.
module ram_arb_sel
    import ram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req_i,
    input  logic              prio_i,
    output logic [NPORTS-1:0] grant_c,
    output logic              id_c,
    output logic              any_c
);

    always_comb begin
        any_c   = |req_i;
        id_c    = PORT_CPU;
        grant_c = '0;
        if (req_i[PORT_LDR] && (!req_i[PORT_CPU] || (prio_i == PORT_LDR))) begin
            id_c = PORT_LDR;
        end
        if (any_c) begin
            grant_c[id_c] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module ram_arbiter #(
    parameter  int unsigned profundidad = 1024,
    parameter  int unsigned NPORTS      = ram_arb_pkg::NPORTS,
    localparam int unsigned AW          = (profundidad > 1) ? $clog2(profundidad) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic [AW-1:0] ram_address,
    output logic [31:0]   ram_write_data,
    output logic          ram_MemWrite,
    output logic          ram_MemRead,
    input  logic [31:0]   ram_read_data
);

    import ram_arb_pkg::*;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                id_q, id_d;
    logic [DW-1:0]       rdata0_q, rdata0_d;
    logic [DW-1:0]       rdata1_q, rdata1_d;
    logic [NPORTS-1:0]   ack_q, ack_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;

    logic [NPORTS-1:0]   req_vec;
    logic [NPORTS-1:0]   grant_c;
    logic                id_c;
    logic                any_c;
    logic                prio_c;

`ifdef RAM_ARB_RR_EN
    logic prio_q, prio_d;
    assign prio_c = prio_q;
`else
    assign prio_c = PORT_CPU;
`endif

    assign req_vec = {req1, req0};

    ram_arb_sel u_sel (
        .req_i   (req_vec),
        .prio_i  (prio_c),
        .grant_c (grant_c),
        .id_c    (id_c),
        .any_c   (any_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack_d    = '0;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
`ifdef RAM_ARB_RR_EN
        prio_d   = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = ACCESS;
                    id_d    = id_c;
                    if (grant_c[PORT_LDR]) begin
                        we_d    = we1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                    end else if (grant_c[PORT_CPU]) begin
                        we_d    = we0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                    end
                    // Strobes are registered so they are high exactly during ACCESS.
                    mem_we_d = we_d;
                    mem_re_d = !we_d;
`ifdef RAM_ARB_RR_EN
                    prio_d   = ~id_c;
`endif
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!we_q) begin
                    if (id_q == PORT_LDR) begin
                        rdata1_d = ram_read_data;
                    end else begin
                        rdata0_d = ram_read_data;
                    end
                end
                ack_d[id_q] = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            id_q     <= PORT_CPU;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack_q    <= '0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack_q    <= ack_d;
            mem_we_q <= mem_we_d;
            mem_re_q <= mem_re_d;
        end
    end

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= PORT_CPU;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign ack0           = ack_q[PORT_CPU];
    assign ack1           = ack_q[PORT_LDR];
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign ram_address    = addr_q;
    assign ram_write_data = wdata_q;
    assign ram_MemWrite   = mem_we_q;
    assign ram_MemRead    = mem_re_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, scoreboard of expected acks, corner-case sequences.
module tb_ram_arbiter;

    localparam int unsigned DEPTH     = 1000;
    localparam int unsigned AW        = 10;
    localparam int unsigned RAM_WORDS = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          ack0, ack1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_write_data;
    logic          ram_MemWrite, ram_MemRead;
    logic [31:0]   ram_read_data;

    ram_arbiter #(.profundidad(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .ack0           (ack0),
        .ack1           (ack1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_MemWrite   (ram_MemWrite),
        .ram_MemRead    (ram_MemRead),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    // RAM with combinational read and a backdoor write port for preloading
    logic [31:0]   ram [0:RAM_WORDS-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    always @(posedge clk) begin
        if (ram_MemWrite) ram[ram_address] <= ram_write_data;
        else if (bd_we)   ram[bd_addr]     <= bd_data;
    end
    assign ram_read_data = ram[ram_address];

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every ack pops one expectation: right port, right rdata
    always @(negedge clk) begin
        if (reset_n && (ack0 || ack1)) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_port", {30'b0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
                check("rdata", e.port ? rdata1 : rdata0, e.rdata);
            end
        end
    end

    task automatic set_req(input logic port, input logic r, input logic we,
                           input logic [AW-1:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1 = r; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = r; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack0"},   32'(ack0), 32'd0);
        check({tag, "_ack1"},   32'(ack1), 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
        check({tag, "_mwr"},    32'(ram_MemWrite), 32'd0);
        check({tag, "_mrd"},    32'(ram_MemRead), 32'd0);
        check({tag, "_addr"},   32'(ram_address), 32'd0);
        check({tag, "_wdata"},  ram_write_data, 32'd0);
    endtask

    // One isolated access: latency, strobe widths and RAM-side values
    task automatic do_access(input vec_t v);
        int nwe, nre, lat;
        nwe = 0; nre = 0; lat = 0;
        @(negedge clk);
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        sb_q.push_back('{port: v.port, rdata: v.exp_rdata});
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            nwe += ram_MemWrite ? 1 : 0;
            nre += ram_MemRead ? 1 : 0;
            if (k == 1) begin
                check("ram_address", 32'(ram_address), 32'(v.addr));
                if (v.we) check("ram_write_data", ram_write_data, v.wdata);
            end
            if (v.port ? ack1 : ack0) lat = k;
        end
        set_req(v.port, 1'b0, 1'b0, v.addr, v.wdata);
        check("latency", 32'(lat), 32'd2);
        check("memwrite_cycles", 32'(nwe), 32'(v.we));
        check("memread_cycles", 32'(nre), 32'(!v.we));
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        int   ack_k[3];
        int   n_ack;
        logic order[5];
        int   n_order;
        int   idx;

        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 10'd5,    wdata: 32'h0,         exp_rdata: 32'hDEADBEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 10'd10,   wdata: 32'h12345678,  exp_rdata: 32'h00000000};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 10'd10,   wdata: 32'h0,         exp_rdata: 32'h12345678};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 10'd0,    wdata: 32'hA5A50000,  exp_rdata: 32'hDEADBEEF};
        vecs[4] = '{port: 1'b1, we: 1'b0, addr: 10'd0,    wdata: 32'h0,         exp_rdata: 32'hA5A50000};
        vecs[5] = '{port: 1'b1, we: 1'b1, addr: 10'd999,  wdata: 32'hCAFEF00D,  exp_rdata: 32'hA5A50000};
        vecs[6] = '{port: 1'b0, we: 1'b1, addr: 10'd1010, wdata: 32'h0BADC0DE,  exp_rdata: 32'hDEADBEEF};
        vecs[7] = '{port: 1'b0, we: 1'b0, addr: 10'd1010, wdata: 32'h0,         exp_rdata: 32'h0BADC0DE};
        vecs[8] = '{port: 1'b1, we: 1'b0, addr: 10'd999,  wdata: 32'h0,         exp_rdata: 32'hCAFEF00D};

        @(negedge clk);
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd20, 32'h11110000);
        check_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) do_access(vecs[i]);

        // Back-to-back: req0 held for three reads, acks every third cycle
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 10'd5, 32'h0);
        for (int i = 0; i < 3; i++) sb_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        n_ack = 0;
        for (int k = 1; k <= 12 && n_ack < 3; k++) begin
            @(negedge clk);
            if (ack0) begin
                ack_k[n_ack] = k;
                n_ack++;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 10'd5, 32'h0);
        check("b2b_count", 32'(n_ack), 32'd3);
        if (n_ack == 3) begin
            check("b2b_ack_a", 32'(ack_k[0]), 32'd2);
            check("b2b_ack_b", 32'(ack_k[1]), 32'd5);
            check("b2b_ack_c", 32'(ack_k[2]), 32'd8);
        end

        // Reset during ACCESS aborts a write
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 10'd20, 32'h55AA55AA);
        @(negedge clk);
        check("abort_mwr_before", 32'(ram_MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        set_req(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_ack", {30'b0, ack1, ack0}, 32'd0);
        end
        reset_n = 1'b1;
        check("abort_ram_unchanged", ram[20], 32'h11110000);
        v = '{port: 1'b1, we: 1'b0, addr: 10'd20, wdata: 32'h0, exp_rdata: 32'h11110000};
        do_access(v);

        // Tie: both ports held continuously; pointer is at port 0 after the reset above
`ifdef RAM_ARB_RR_EN
        order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1; order[4] = 1'b0;
        n_order = 5;
`else
        order[0] = 1'b0; order[1] = 1'b0; order[2] = 1'b1; order[3] = 1'b0; order[4] = 1'b0;
        n_order = 3;
`endif
        for (int i = 0; i < n_order; i++) begin
            sb_q.push_back('{port: order[i], rdata: order[i] ? 32'h12345678 : 32'hDEADBEEF});
        end
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 10'd5, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 10'd10, 32'h0);
        idx = 0;
        for (int k = 1; k <= 40 && idx < n_order; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                check("tie_order", 32'(ack1), 32'(order[idx]));
                idx++;
`ifdef RAM_ARB_RR_EN
                if (idx == 4) req1 = 1'b0;
                if (idx == 5) req0 = 1'b0;
`else
                if (idx == 2) req0 = 1'b0;
                if (idx == 3) req1 = 1'b0;
`endif
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie_count", 32'(idx), 32'(n_order));

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
